// File: rtl/sprite_compositor.sv
// N-channel sprite engine: double-buffered sprite registers, per-sprite hit test
// driving a synchronous ROM port, then fixed-priority colour-key compositing.

module sprite_channel #(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_x_i,
    input  logic              wr_y_i,
    input  logic              wr_ctrl_i,
    input  logic [10:0]       wdata_i,
    input  logic              frame_start_i,
    input  logic [10:0]       hcount_i,
    input  logic [9:0]        vcount_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              hit_o
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    logic [10:0]       px_q, ax_q;
    logic [9:0]        py_q, ay_q;
    logic [2:0]        pctl_q, actl_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [1:0]        hit_q;

    logic              in_x, in_y, hit_d;
    logic [CW-1:0]     col_d;
    logic [RW-1:0]     row_d;
    logic [ADDR_W-1:0] addr_d;

    // Active set copies pending before this cycle's write lands, so a write
    // coinciding with frame_start waits for the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px_q   <= '0;
            py_q   <= '0;
            pctl_q <= '0;
            ax_q   <= '0;
            ay_q   <= '0;
            actl_q <= '0;
        end else begin
            if (frame_start_i) begin
                ax_q   <= px_q;
                ay_q   <= py_q;
                actl_q <= pctl_q;
            end
            if (wr_x_i)    px_q   <= wdata_i;
            if (wr_y_i)    py_q   <= wdata_i[9:0];
            if (wr_ctrl_i) pctl_q <= wdata_i[2:0];
        end
    end

    // One extra bit on the compare keeps X+SPRITE_W from wrapping to column 0.
    always_comb begin
        in_x   = ({1'b0, hcount_i} >= {1'b0, ax_q}) &&
                 ({1'b0, hcount_i} <  ({1'b0, ax_q} + 12'(SPRITE_W)));
        in_y   = ({1'b0, vcount_i} >= {1'b0, ay_q}) &&
                 ({1'b0, vcount_i} <  ({1'b0, ay_q} + 11'(SPRITE_H)));
        hit_d  = actl_q[0] && in_x && in_y;
        col_d  = (hcount_i[CW-1:0] - ax_q[CW-1:0]) ^ {CW{actl_q[1]}};
        row_d  = (vcount_i[RW-1:0] - ay_q[RW-1:0]) ^ {RW{actl_q[2]}};
        addr_d = hit_d ? ADDR_W'({row_d, col_d}) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            hit_q      <= '0;
        end else begin
            rom_addr_q <= addr_d;
            hit_q      <= {hit_q[0], hit_d};
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign hit_o      = hit_q[1];
endmodule

module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          ADDR_W      = 10,
    parameter logic [15:0] BG_RESET    = 16'hFFFF,
    parameter logic [15:0] KEY_RESET   = 16'hF81F
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [8:0]                    address,
    input  logic [31:0]                   writedata,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          blank_n_in,
    input  logic                          frame_start,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*16-1:0]     rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          blank_n_out
);
    logic                   wr;
    logic [15:0]            bg_q, key_q;
    logic [2:0]             vld_pipe_q;
    logic [23:0]            rgb_q;
    logic [NUM_SPRITES-1:0] hit;
    logic [15:0]            pix_d;
    logic [15:0]            unused_wdata;

    assign wr           = chipselect & write;
    assign unused_wdata = writedata[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bg_q  <= BG_RESET;
            key_q <= KEY_RESET;
        end else begin
            if (wr && address == 9'h100) bg_q  <= writedata[15:0];
            if (wr && address == 9'h101) key_q <= writedata[15:0];
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        logic sel;
        assign sel = wr && (address[8:2] == 7'(i));

        sprite_channel #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (ADDR_W)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .wr_x_i        (sel && address[1:0] == 2'd0),
            .wr_y_i        (sel && address[1:0] == 2'd1),
            .wr_ctrl_i     (sel && address[1:0] == 2'd2),
            .wdata_i       (writedata[10:0]),
            .frame_start_i (frame_start),
            .hcount_i      (hcount),
            .vcount_i      (vcount),
            .rom_addr_o    (rom_addr[i*ADDR_W +: ADDR_W]),
            .hit_o         (hit[i])
        );
    end

    // Walk from the highest index down so the lowest opaque sprite wins.
    always_comb begin
        pix_d = bg_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i] && rom_data[i*16 +: 16] != key_q)
                pix_d = rom_data[i*16 +: 16];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            rgb_q      <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1:0], blank_n_in};
            rgb_q      <= vld_pipe_q[1] ?
                          {pix_d[15:11], 3'b000, pix_d[10:5], 2'b00, pix_d[4:0], 3'b000} : '0;
        end
    end

    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign blank_n_out = vld_pipe_q[2];
endmodule
